// File: rtl/counter_modn.sv
// Modulo-N up/down counter with setting mode, parallel load, cascade carry,
// early-warning pre-carry and registered BCD digits. One instance serves as a
// seconds, minutes or hours digit pair; carry_out feeds the next stage's enable.
module counter_modn #(
   parameter int unsigned MODULUS       = 60,
   parameter int unsigned WIDTH         = 7,
   parameter int unsigned PRECARRY_LEAD = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             down,
   input  logic             set_mode,
   input  logic             set_inc,
   input  logic             set_dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] count,
   output logic [3:0]       count_tens,
   output logic [3:0]       count_ones,
   output logic             carry_out,
   output logic             pre_carry
);

   localparam logic [WIDTH-1:0] MaxVal    = WIDTH'(MODULUS - 1);
   localparam logic [3:0]       MaxTens   = 4'((MODULUS - 1) / 10);
   localparam logic [3:0]       MaxOnes   = 4'((MODULUS - 1) % 10);
   localparam bit               PreEnable = (MODULUS - 1) >= (PRECARRY_LEAD + 1);
   // Lowest count at which pre_carry is raised when counting up
   localparam logic [WIDTH-1:0] UpLo      =
      PreEnable ? WIDTH'(MODULUS - 1 - PRECARRY_LEAD) : '0;
   // Highest count at which pre_carry is raised when counting down
   localparam logic [WIDTH-1:0] DnHi      = WIDTH'(PRECARRY_LEAD);

   logic [WIDTH-1:0] count_q, count_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       ones_q, ones_d;
   logic             pre_carry_q, pre_carry_d;

   logic [WIDTH-1:0] load_sat;
   logic [7:0]       load_rem;
   logic [3:0]       load_tens;
   logic [3:0]       load_ones;
   logic             step_up, step_dn;
   logic             terminal;

   // Saturate the load value and split it into BCD by repeated subtraction
   always_comb begin
      load_sat  = (load_data > MaxVal) ? MaxVal : load_data;
      load_rem  = 8'(load_sat);
      load_tens = '0;
      for (int i = 0; i < 9; i++) begin
         if (load_rem >= 8'd10) begin
            load_rem  = load_rem - 8'd10;
            load_tens = load_tens + 4'd1;
         end
      end
      load_ones = load_rem[3:0];
   end

   // Decode a single up/down step from the active mode; load suppresses stepping
   always_comb begin
      step_up = 1'b0;
      step_dn = 1'b0;
      if (!load) begin
         if (set_mode) begin
            step_up = set_inc & ~set_dec;
            step_dn = set_dec & ~set_inc;
         end else begin
            step_up = enable & ~down;
            step_dn = enable & down;
         end
      end
   end

   // Zero-latency cascade pulse on the edge that performs a run-mode wrap
   always_comb begin
      terminal  = down ? (count_q == '0) : (count_q == MaxVal);
      carry_out = ~reset & ~load & ~set_mode & enable & terminal;
   end

   // Next binary count and BCD digits, kept in lock-step
   always_comb begin
      count_d = count_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      if (load) begin
         count_d = load_sat;
         tens_d  = load_tens;
         ones_d  = load_ones;
      end else if (step_up) begin
         if (count_q == MaxVal) begin
            count_d = '0;
            tens_d  = '0;
            ones_d  = '0;
         end else begin
            count_d = count_q + WIDTH'(1);
            if (ones_q == 4'd9) begin
               ones_d = '0;
               tens_d = tens_q + 4'd1;
            end else begin
               ones_d = ones_q + 4'd1;
            end
         end
      end else if (step_dn) begin
         if (count_q == '0) begin
            count_d = MaxVal;
            tens_d  = MaxTens;
            ones_d  = MaxOnes;
         end else begin
            count_d = count_q - WIDTH'(1);
            if (ones_q == 4'd0) begin
               ones_d = 4'd9;
               tens_d = tens_q - 4'd1;
            end else begin
               ones_d = ones_q - 4'd1;
            end
         end
      end
   end

   // Pre-carry is derived from the next count so it never lags the count
   always_comb begin
      pre_carry_d = 1'b0;
      if (PreEnable) begin
         if (down) begin
            pre_carry_d = (count_d != '0) && (count_d <= DnHi);
         end else begin
            pre_carry_d = (count_d >= UpLo) && (count_d < MaxVal);
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q     <= '0;
         tens_q      <= '0;
         ones_q      <= '0;
         pre_carry_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         pre_carry_q <= pre_carry_d;
      end
   end

   assign count      = count_q;
   assign count_tens = tens_q;
   assign count_ones = ones_q;
   assign pre_carry  = pre_carry_q;

endmodule

// File: tb/tb_counter_modn.sv
// Bench for counter_modn: a seconds stage (mod 60, lead 1) cascaded into an
// hours stage (mod 24, lead 0), checked against a modular-arithmetic model.
module tb_counter_modn;

   logic       clock;
   logic       reset;
   logic       enable, down, set_mode, set_inc, set_dec, load;
   logic [6:0] load_data;
   logic [6:0] s_count;
   logic [3:0] s_tens, s_ones;
   logic       s_carry, s_pre;
   logic       h_load;
   logic [4:0] h_load_data;
   logic [4:0] h_count;
   logic [3:0] h_tens, h_ones;
   logic       h_carry, h_pre;

   int checks = 0;
   int passed = 0;

   // Model state
   int sc = 0, hc = 0;
   bit sp = 0, hp = 0;

   counter_modn #(.MODULUS(60), .WIDTH(7), .PRECARRY_LEAD(1)) u_sec (
      .clock(clock), .reset(reset), .enable(enable), .down(down),
      .set_mode(set_mode), .set_inc(set_inc), .set_dec(set_dec),
      .load(load), .load_data(load_data), .count(s_count),
      .count_tens(s_tens), .count_ones(s_ones), .carry_out(s_carry), .pre_carry(s_pre)
   );

   counter_modn #(.MODULUS(24), .WIDTH(5), .PRECARRY_LEAD(0)) u_hr (
      .clock(clock), .reset(reset), .enable(s_carry), .down(down),
      .set_mode(1'b0), .set_inc(1'b0), .set_dec(1'b0),
      .load(h_load), .load_data(h_load_data), .count(h_count),
      .count_tens(h_tens), .count_ones(h_ones), .carry_out(h_carry), .pre_carry(h_pre)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input int exp);
      checks++;
      assert (act === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
   endtask

   function automatic int model_next(input int c, input int m, input bit rst, input bit ld,
                                     input int ld_data, input bit sm, input bit si,
                                     input bit sd, input bit en, input bit dn);
      if (rst) return 0;
      if (ld) return (ld_data > m - 1) ? m - 1 : ld_data;
      if (sm) begin
         if (si && !sd) return (c + 1) % m;
         if (sd && !si) return (c + m - 1) % m;
         return c;
      end
      if (en) return dn ? (c + m - 1) % m : (c + 1) % m;
      return c;
   endfunction

   function automatic bit model_pre(input int c, input int m, input int l, input bit dn);
      if (m - 1 < l + 1) return 1'b0;
      if (dn) return (c > 0) && (c <= l);
      return (c >= m - 1 - l) && (c < m - 1);
   endfunction

   function automatic bit model_carry(input int c, input int m, input bit rst, input bit ld,
                                      input bit sm, input bit en, input bit dn);
      return !rst && !ld && !sm && en && (dn ? (c == 0) : (c == m - 1));
   endfunction

   // One clock: drive inputs, check carries before the edge, check state after it
   task automatic cycle(input bit rst, input bit ld, input int ld_data, input bit sm,
                        input bit si, input bit sd, input bit en, input bit dn,
                        input bit hld, input int hld_data);
      bit sco, hco;
      reset = rst; load = ld; load_data = 7'(ld_data); set_mode = sm;
      set_inc = si; set_dec = sd; enable = en; down = dn;
      h_load = hld; h_load_data = 5'(hld_data);
      @(negedge clock);
      sco = model_carry(sc, 60, rst, ld, sm, en, dn);
      hco = model_carry(hc, 24, rst, hld, 1'b0, sco, dn);
      check("sec_carry", 32'(s_carry), int'(sco));
      check("hr_carry", 32'(h_carry), int'(hco));
      @(posedge clock);
      sc = model_next(sc, 60, rst, ld, ld_data, sm, si, sd, en, dn);
      hc = model_next(hc, 24, rst, hld, hld_data, 1'b0, 1'b0, 1'b0, sco, dn);
      sp = rst ? 1'b0 : model_pre(sc, 60, 1, dn);
      hp = rst ? 1'b0 : model_pre(hc, 24, 0, dn);
      #1;
      check("sec_count", 32'(s_count), sc);
      check("sec_tens", 32'(s_tens), sc / 10);
      check("sec_ones", 32'(s_ones), sc % 10);
      check("sec_pre", 32'(s_pre), int'(sp));
      check("hr_count", 32'(h_count), hc);
      check("hr_tens", 32'(h_tens), hc / 10);
      check("hr_ones", 32'(h_ones), hc % 10);
      check("hr_pre", 32'(h_pre), int'(hp));
   endtask

   initial begin
      reset = 1'b1; enable = 0; down = 0; set_mode = 0; set_inc = 0; set_dec = 0;
      load = 0; load_data = '0; h_load = 0; h_load_data = '0;
      @(posedge clock);
      #1;
      // Reset state
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // 60 up-count enables with a couple of idle cycles interleaved
      for (int i = 0; i < 60; i++) begin
         cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
         if (i % 20 == 5) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      // Down count from a load of 2
      cycle(0, 1, 2, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      // Setting mode at 59: inc wraps without carry, dec, both, enable ignored
      cycle(0, 1, 59, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
      // Saturating load, and load beating set_mode and enable
      cycle(0, 1, 73, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 40, 1, 0, 0, 1, 0, 0, 0);
      // Cascade 23:59 -> 00:00
      cycle(0, 1, 59, 0, 0, 0, 0, 0, 1, 23);
      cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      // Reset at 37 with enable high, then resume
      cycle(0, 1, 37, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
               int'($urandom_range(0, 127)), ($urandom_range(0, 7) == 0),
               1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0),
               int'($urandom_range(0, 31)));
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
